kfmmc_command_sequencer: RTL
============================

KFMMC_COMMAND_SEQUENCER -- requirements
Module: kfmmc_command_sequencer

Interface
REQ-001 The block SHALL have one parameter: PAD_BYTES, default 1, the number of 0xFF bytes clocked out after each command sequence.
REQ-002 The block SHALL use one clock, and reset SHALL be synchronous and active-high.
REQ-003 The block SHALL have these ports:
- clock  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high
- cmd_start  in  1  request pulse; accepted only while idle
- cmd_index  in  6  command index
- cmd_argument  in  32  command argument, sent MSB first
- response_type  in  2  00 none, 01 R48 checked, 10 R48 unchecked, 11 R136
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse
- response  out  136  received bytes, shifted in at the LSB end
- response_timeout  out  1  timeout seen during the sequence
- response_error  out  1  CRC7 mismatch or end bit = 0 (type 01 only)
- if_start_communication  out  1  one-cycle strobe to the byte interface
- if_command_io  out  1  0 = send, 1 = receive
- if_check_command_start_bit  out  1  wait for a new start bit
- if_clear_command_crc  out  1  clear both CRC accumulators
- if_set_send_command  out  1  load if_send_command
- if_send_command  out  8  byte to transmit
- if_received_response  in  8  last received byte
- if_send_command_crc  in  7  running CRC7 of sent bits
- if_received_response_crc  in  7  running CRC7 of received bits
- if_sent_command_interrupt  in  1  byte sent
- if_received_response_interrupt  in  1  byte received
- if_timeout_interrupt  in  1  no start bit within the timeout

Function
REQ-004 The FSM SHALL have the states IDLE, TX_ISSUE, TX_WAIT, RX_ISSUE, RX_WAIT, PAD_ISSUE, PAD_WAIT and FINISH.
REQ-005 In IDLE, cmd_start SHALL latch all inputs, clear response and both flags, set busy, and go to TX_ISSUE with byte counter = 0.
REQ-006 In every state except IDLE, cmd_start SHALL be ignored.
REQ-007 Each *_ISSUE state SHALL last exactly one cycle, asserting if_start_communication together with the strobes for that byte.
REQ-008 Each *_WAIT state SHALL ignore all interface interrupts in its first cycle (guard cycle) and sample them from its second cycle onward.
REQ-009 The transmitted bytes SHALL be, in order: byte0 = {2'b01, cmd_index}; bytes 1-4 = cmd_argument[31:24] down to [7:0]; byte5 = {if_send_command_crc, 1'b1}.
- Byte5's CRC SHALL be sampled in the cycle TX_WAIT for byte4 exits.
REQ-010 The TX_ISSUE strobes SHALL be: if_command_io = 0, if_set_send_command = 1, and if_clear_command_crc = 1 for byte0 only.
REQ-011 After if_sent_command_interrupt for byte5:
- response_type 00 SHALL go to PAD_ISSUE.
- Any other response_type SHALL go to RX_ISSUE.
REQ-012 RX_ISSUE SHALL drive if_command_io = 1, with if_check_command_start_bit = 1 for the first response byte only.
REQ-013 On if_received_response_interrupt, the block SHALL perform response <= {response[127:0], if_received_response} and increment the receive count.
REQ-014 The number of response bytes SHALL be 6 for types 01/10 and 17 for type 11; after the last byte the FSM SHALL go to PAD_ISSUE.
REQ-015 For type 01, if_received_response_crc SHALL be latched when the 5th byte arrives.
- response_error SHALL be set if the 6th byte[7:1] differs from that latched value, or if the 6th byte[0] = 0.
- Types 00, 10 and 11 SHALL never set response_error.
REQ-016 If if_timeout_interrupt is seen in any *_WAIT state after its guard cycle:
- response_timeout SHALL be set, and the FSM SHALL go directly to PAD_ISSUE.
- Timeout SHALL take priority over a simultaneous byte interrupt.
REQ-017 The PAD phase SHALL send PAD_BYTES bytes of 0xFF (if_command_io = 0, no CRC clear), then go to FINISH.
- PAD_BYTES = 0 SHALL skip the PAD phase.
REQ-018 FINISH SHALL pulse done for one cycle, clear busy, set if_command_io = 1, and return to IDLE.
REQ-019 response and both flags SHALL hold their values until the next accepted cmd_start.
REQ-020 All byte and pad counters SHALL be sized so they never wrap within a sequence.

Reset
REQ-021 Reset SHALL force, on the next rising edge: IDLE; busy = 0, done = 0, response = 0, response_timeout = 0, response_error = 0.
REQ-022 Reset SHALL also force: if_start_communication = 0, if_command_io = 1, if_check_command_start_bit = 0, if_clear_command_crc = 0, if_set_send_command = 0, if_send_command = 0xFF.
REQ-023 A reset mid-sequence SHALL abandon the sequence with no done pulse.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- CMD0, argument 0, type 00, PAD_BYTES = 1 -> bytes 0x40, 0x00, 0x00, 0x00, 0x00, 0x95, then 0xFF; one done pulse; both flags 0.
- CMD8, argument 0x000001AA, type 01; model replies with a valid R7 -> last sent byte 0x87; response[47:0] = received bytes; response_error = 0.
- As the previous scenario, but the model flips one CRC bit -> response_error = 1; response_timeout = 0; done pulses.
- CMD2, type 11; model returns 17 bytes -> response[135:0] holds all 17 in arrival order; response_error = 0.
- Type 01 with no reply; model asserts if_timeout_interrupt -> response_timeout = 1, 0xFF pad sent, done pulses.
- cmd_start during TX_WAIT is ignored; reset asserted during RX_WAIT -> next cycle busy = 0, if_command_io = 1, no done pulse.

Source files
------------

// File: rtl/kfmmc_command_sequencer.sv
// Drives one SD/MMC command frame through the byte interface: six command bytes,
// an optional 6- or 17-byte response with CRC7 check, PAD_BYTES 0xFF bytes, then done.
module kfmmc_command_sequencer #(
    parameter int PAD_BYTES = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         cmd_start,
    input  logic [5:0]   cmd_index,
    input  logic [31:0]  cmd_argument,
    input  logic [1:0]   response_type,
    output logic         busy,
    output logic         done,
    output logic [135:0] response,
    output logic         response_timeout,
    output logic         response_error,
    output logic         if_start_communication,
    output logic         if_command_io,
    output logic         if_check_command_start_bit,
    output logic         if_clear_command_crc,
    output logic         if_set_send_command,
    output logic [7:0]   if_send_command,
    input  logic [7:0]   if_received_response,
    input  logic [6:0]   if_send_command_crc,
    input  logic [6:0]   if_received_response_crc,
    input  logic         if_sent_command_interrupt,
    input  logic         if_received_response_interrupt,
    input  logic         if_timeout_interrupt
);

    typedef enum logic [2:0] {
        IDLE, TX_ISSUE, TX_WAIT, RX_ISSUE, RX_WAIT, PAD_ISSUE, PAD_WAIT, FINISH
    } state_t;

    localparam int     PAD_W     = (PAD_BYTES < 2) ? 1 : $clog2(PAD_BYTES + 1);
    localparam state_t PAD_ENTRY = (PAD_BYTES == 0) ? FINISH : PAD_ISSUE;

    state_t             state_q, state_d;
    logic [4:0]         byte_cnt_q, byte_cnt_d;
    logic [PAD_W-1:0]   pad_cnt_q, pad_cnt_d;
    logic               guard_q, guard_d;
    logic [5:0]         index_q, index_d;
    logic [31:0]        arg_q, arg_d;
    logic [1:0]         rtype_q, rtype_d;
    logic [135:0]       response_q, response_d;
    logic               timeout_q, timeout_d;
    logic               error_q, error_d;
    logic [6:0]         rx_crc_q, rx_crc_d;
    logic [6:0]         tx_crc_q, tx_crc_d;
    logic [7:0]         tx_byte;
    logic               rx_last;
    logic               pad_last;

    always_comb begin
        tx_byte = 8'hFF;
        case (byte_cnt_q)
            5'd0:    tx_byte = {2'b01, index_q};
            5'd1:    tx_byte = arg_q[31:24];
            5'd2:    tx_byte = arg_q[23:16];
            5'd3:    tx_byte = arg_q[15:8];
            5'd4:    tx_byte = arg_q[7:0];
            5'd5:    tx_byte = {tx_crc_q, 1'b1};
            default: tx_byte = 8'hFF;
        endcase
    end

    assign rx_last  = (byte_cnt_q == ((rtype_q == 2'b11) ? 5'd16 : 5'd5));
    assign pad_last = ((int'(pad_cnt_q) + 1) == PAD_BYTES);

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        pad_cnt_d  = pad_cnt_q;
        guard_d    = guard_q;
        index_d    = index_q;
        arg_d      = arg_q;
        rtype_d    = rtype_q;
        response_d = response_q;
        timeout_d  = timeout_q;
        error_d    = error_q;
        rx_crc_d   = rx_crc_q;
        tx_crc_d   = tx_crc_q;

        done                       = 1'b0;
        if_start_communication     = 1'b0;
        if_command_io              = 1'b1;
        if_check_command_start_bit = 1'b0;
        if_clear_command_crc       = 1'b0;
        if_set_send_command        = 1'b0;
        if_send_command            = 8'hFF;

        case (state_q)
            IDLE: begin
                if (cmd_start) begin
                    index_d    = cmd_index;
                    arg_d      = cmd_argument;
                    rtype_d    = response_type;
                    response_d = '0;
                    timeout_d  = 1'b0;
                    error_d    = 1'b0;
                    byte_cnt_d = '0;
                    pad_cnt_d  = '0;
                    state_d    = TX_ISSUE;
                end
            end
            TX_ISSUE: begin
                if_start_communication = 1'b1;
                if_command_io          = 1'b0;
                if_set_send_command    = 1'b1;
                if_clear_command_crc   = (byte_cnt_q == 5'd0);
                if_send_command        = tx_byte;
                guard_d                = 1'b1;
                state_d                = TX_WAIT;
            end
            TX_WAIT: begin
                if_command_io   = 1'b0;
                if_send_command = tx_byte;
                if (guard_q) begin
                    guard_d = 1'b0;
                end else if (if_timeout_interrupt) begin
                    timeout_d = 1'b1;
                    state_d   = PAD_ENTRY;
                end else if (if_sent_command_interrupt) begin
                    // The interface CRC covers bytes 0-4 only at this moment.
                    if (byte_cnt_q == 5'd4) tx_crc_d = if_send_command_crc;
                    if (byte_cnt_q == 5'd5) begin
                        byte_cnt_d = '0;
                        state_d    = (rtype_q == 2'b00) ? PAD_ENTRY : RX_ISSUE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 5'd1;
                        state_d    = TX_ISSUE;
                    end
                end
            end
            RX_ISSUE: begin
                if_start_communication     = 1'b1;
                if_check_command_start_bit = (byte_cnt_q == 5'd0);
                guard_d                    = 1'b1;
                state_d                    = RX_WAIT;
            end
            RX_WAIT: begin
                if (guard_q) begin
                    guard_d = 1'b0;
                end else if (if_timeout_interrupt) begin
                    timeout_d = 1'b1;
                    state_d   = PAD_ENTRY;
                end else if (if_received_response_interrupt) begin
                    response_d = {response_q[127:0], if_received_response};
                    byte_cnt_d = byte_cnt_q + 5'd1;
                    if (rtype_q == 2'b01 && byte_cnt_q == 5'd4) rx_crc_d = if_received_response_crc;
                    if (rtype_q == 2'b01 && byte_cnt_q == 5'd5)
                        error_d = (if_received_response[7:1] != rx_crc_q) || !if_received_response[0];
                    state_d = rx_last ? PAD_ENTRY : RX_ISSUE;
                end
            end
            PAD_ISSUE: begin
                if_start_communication = 1'b1;
                if_command_io          = 1'b0;
                if_set_send_command    = 1'b1;
                guard_d                = 1'b1;
                state_d                = PAD_WAIT;
            end
            PAD_WAIT: begin
                if_command_io = 1'b0;
                if (guard_q) begin
                    guard_d = 1'b0;
                end else if (if_timeout_interrupt || if_sent_command_interrupt) begin
                    if (if_timeout_interrupt) timeout_d = 1'b1;
                    if (pad_last) begin
                        state_d = FINISH;
                    end else begin
                        pad_cnt_d = pad_cnt_q + 1'b1;
                        state_d   = PAD_ISSUE;
                    end
                end
            end
            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            pad_cnt_q  <= '0;
            guard_q    <= 1'b0;
            index_q    <= '0;
            arg_q      <= '0;
            rtype_q    <= '0;
            response_q <= '0;
            timeout_q  <= 1'b0;
            error_q    <= 1'b0;
            rx_crc_q   <= '0;
            tx_crc_q   <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            pad_cnt_q  <= pad_cnt_d;
            guard_q    <= guard_d;
            index_q    <= index_d;
            arg_q      <= arg_d;
            rtype_q    <= rtype_d;
            response_q <= response_d;
            timeout_q  <= timeout_d;
            error_q    <= error_d;
            rx_crc_q   <= rx_crc_d;
            tx_crc_q   <= tx_crc_d;
        end
    end

    assign busy             = (state_q != IDLE);
    assign response         = response_q;
    assign response_timeout = timeout_q;
    assign response_error   = error_q;

endmodule
